// File: rtl/dmem_xlate_issue.sv
// Data-side VA->PA translation and SRAM-like request issue between EX and MEM.
// Tracks accepted-but-unanswered requests and swallows responses orphaned by a flush.
module dmem_xlate_issue #(
  parameter int NUM_DMW   = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_va,
  input  logic                   in_wr,
  input  logic [1:0]             in_size,
  input  logic [31:0]            in_wdata,
  input  logic [6:0]             in_exc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [6:0]             out_exc,
  output logic                   out_issued,
  output logic [19:0]            tlb_va_hi,
  input  logic [30:0]            tlb_res,
  input  logic                   crmd_pg,
  input  logic [1:0]             crmd_plv,
  input  logic [7*NUM_DMW-1:0]   dmw_cfg,
  output logic                   data_req,
  output logic                   data_wr,
  output logic [1:0]             data_size,
  output logic [3:0]             data_wstrb,
  output logic [31:0]            data_addr,
  output logic [31:0]            data_wdata,
  input  logic                   data_addr_ok,
  input  logic                   data_data_ok,
  output logic                   mem_data_ok
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_PME  = 6'h04;

  // Handshakes: a transfer happens on the cycle valid&ready (or req&addr_ok) is high;
  // the producer keeps valid/req and all payload fields stable until then.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_XLATE = 3'd1,
    S_ISSUE = 3'd2,
    S_OUT   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   va_q, wdata_q, pa_q, bus_wdata_q;
  logic          wr_q, issued_q;
  logic [1:0]    size_q;
  logic [6:0]    exc_q;
  logic [3:0]    wstrb_q;
  logic [CW-1:0] outst_q, outst_d, disc_q, disc_d;

  logic accept, inc, dec, flush_hit, disc_nz;

  // TLB result fields
  logic       tlb_found, tlb_v, tlb_d;
  logic [1:0] tlb_plv;
  logic [5:0] tlb_ps;
  logic [19:0] tlb_ppn;

  assign {tlb_found, tlb_v, tlb_d, tlb_plv, tlb_ps, tlb_ppn} = tlb_res;
  assign tlb_va_hi = va_q[31:12];

  // Direct-map window match; iterating downward lets the lowest index win.
  logic       dmw_hit;
  logic [2:0] dmw_pseg;

  always_comb begin
    dmw_hit  = 1'b0;
    dmw_pseg = 3'd0;
    for (int i = NUM_DMW - 1; i >= 0; i--) begin
      if (dmw_cfg[7*i+6] && (dmw_cfg[7*i+3 +: 3] == va_q[31:29])) begin
        dmw_hit  = 1'b1;
        dmw_pseg = dmw_cfg[7*i +: 3];
      end
    end
  end

  logic [31:0] xl_pa, xl_wdata;
  logic [6:0]  xl_exc;
  logic [3:0]  xl_wstrb;
  logic        ale, tlb_chk;

  always_comb begin
    xl_pa = va_q;
    if (crmd_pg) begin
      if (dmw_hit)              xl_pa = {dmw_pseg, va_q[28:0]};
      else if (tlb_ps == 6'd21) xl_pa = {tlb_ppn[19:9], va_q[20:0]};
      else                      xl_pa = {tlb_ppn, va_q[11:0]};
    end

    ale     = ((size_q == 2'd1) && va_q[0]) || ((size_q == 2'd2) && (va_q[1:0] != 2'b00));
    tlb_chk = crmd_pg && !dmw_hit;

    xl_exc = exc_q;
    if (!exc_q[6]) begin
      if (ale)                               xl_exc = {1'b1, ECODE_ALE};
      else if (tlb_chk && !tlb_found)        xl_exc = {1'b1, ECODE_TLBR};
      else if (tlb_chk && !tlb_v)            xl_exc = {1'b1, wr_q ? ECODE_PIS : ECODE_PIL};
      else if (tlb_chk && (tlb_plv < crmd_plv)) xl_exc = {1'b1, ECODE_PPI};
      else if (tlb_chk && wr_q && !tlb_d)    xl_exc = {1'b1, ECODE_PME};
    end

    case (size_q)
      2'd0: begin
        xl_wstrb = 4'b0001 << xl_pa[1:0];
        xl_wdata = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        xl_wstrb = xl_pa[1] ? 4'b1100 : 4'b0011;
        xl_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        xl_wstrb = 4'b1111;
        xl_wdata = wdata_q;
      end
    endcase
  end

  assign in_ready  = ((state_q == S_IDLE) || ((state_q == S_OUT) && out_ready)) &&
                     (outst_q < MAX_CNT) && !flush;
  assign accept    = in_valid && in_ready;
  assign data_req  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign out_valid = (state_q == S_OUT);

  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = pa_q;
  assign data_wstrb = wstrb_q;
  assign data_wdata = bus_wdata_q;
  assign out_exc    = exc_q;
  assign out_issued = issued_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_XLATE;
      S_XLATE: begin
        if (flush)          state_d = S_IDLE;
        else if (xl_exc[6]) state_d = S_OUT;
        else                state_d = S_ISSUE;
      end
      // A request already on the bus cannot be retracted, so a flush waits it out.
      S_ISSUE: begin
        if (flush)             state_d = data_addr_ok ? S_IDLE : S_DRAIN;
        else if (data_addr_ok) state_d = S_OUT;
      end
      S_OUT: begin
        if (flush)          state_d = S_IDLE;
        else if (out_ready) state_d = accept ? S_XLATE : S_IDLE;
      end
      S_DRAIN: if (data_addr_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Every outstanding response at flush time becomes a discard, including the
  // drained request; the flush-cycle data_ok is dropped rather than counted.
  assign inc       = data_req && data_addr_ok;
  assign dec       = data_data_ok;
  assign flush_hit = flush && (state_q != S_DRAIN);
  assign disc_nz   = (disc_q != '0);
  assign mem_data_ok = dec && !disc_nz && !flush_hit;

  always_comb begin
    outst_d = outst_q + CW'(inc) - CW'(dec);
    disc_d  = disc_q + CW'(inc && (state_q == S_DRAIN)) - CW'(dec && disc_nz);
    if (flush_hit) disc_d = outst_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      outst_q     <= '0;
      disc_q      <= '0;
      va_q        <= '0;
      wr_q        <= 1'b0;
      size_q      <= 2'd0;
      wdata_q     <= '0;
      exc_q       <= '0;
      pa_q        <= '0;
      wstrb_q     <= '0;
      bus_wdata_q <= '0;
      issued_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      disc_q  <= disc_d;
      if (accept) begin
        va_q    <= in_va;
        wr_q    <= in_wr;
        size_q  <= in_size;
        wdata_q <= in_wdata;
        exc_q   <= in_exc;
      end else if (state_q == S_XLATE) begin
        pa_q        <= xl_pa;
        exc_q       <= xl_exc;
        wstrb_q     <= xl_wstrb;
        bus_wdata_q <= xl_wdata;
        issued_q    <= 1'b0;
      end else if ((state_q == S_ISSUE) && data_addr_ok && !flush) begin
        issued_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) assert (!(data_data_ok && (outst_q == '0)));
  end

endmodule
